// File: rtl/addsub_result_buffer.sv
// -----------------------------------------------------------------------------
// addsub_result_buffer
//
// Capture stage behind the 4-bit adder/subtractor. The buffer accepts each word
// that arrives with in_valid while it has space. It decorates the word with ALU
// flags {M,Z,N,V,C} and queues it in a DEPTH-entry first-word-fall-through FIFO.
// A consumer drains the FIFO over a valid/ready handshake.
//
// Two registers give software-visible overflow status:
//   - sticky_v  : set by any accepted word that has V=1.
//   - ovf_count : counts accepted words that have V=1, and saturates.
// clr clears both. clr does not touch the FIFO.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        producer handshake (in_ready = !full)
//   in_result, in_v,           producer word: result, signed overflow,
//   in_c_out, in_m             raw carry out, operation (0=add, 1=sub)
//   out_valid / out_ready      consumer handshake (out_valid = !empty)
//   out_result, out_flags      head entry, or 0 when the FIFO is empty
//   clr                        synchronous clear of sticky_v / ovf_count
//   sticky_v, ovf_count        overflow status
//   count                      number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module addsub_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_result,
    input  logic                     in_v,
    input  logic                     in_c_out,
    input  logic                     in_m,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_result,
    output logic [4:0]               out_flags,
    input  logic                     clr,
    output logic                     sticky_v,
    output logic [CNT_W-1:0]         ovf_count,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // Each stored word is {result[3:0], flags[4:0]}
    logic [8:0]       mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             sticky_reg;
    logic [CNT_W-1:0] ovf_reg;

    logic             push;
    logic             pop;
    logic [4:0]       push_flags;
    logic [8:0]       push_word;
    logic [8:0]       head_word;
    logic             push_ovf;

    // The handshake uses only the registered count, so out_ready has no
    // combinational path to in_ready.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Flags {M,Z,N,V,C}. C is passed through raw: for a subtract, C=1 means
    // no borrow.
    assign push_flags = {in_m, (in_result == 4'h0), in_result[3], in_v, in_c_out};
    assign push_word  = {in_result, push_flags};
    assign push_ovf   = push & in_v;

    // Storage has no reset. Contents are don't-care until count marks them
    // valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    // First-word-fall-through head. The outputs are forced to 0 while empty.
    assign head_word  = mem[rd_ptr_reg];
    assign out_result = out_valid ? head_word[8:5] : 4'h0;
    assign out_flags  = out_valid ? head_word[4:0] : 5'h00;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // When clr arrives in the same cycle as an overflowing push, the push is
    // the first event after the clear. That leaves the count at 1, not 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= 1'b0;
            ovf_reg    <= '0;
        end else if (clr) begin
            sticky_reg <= push_ovf;
            ovf_reg    <= push_ovf ? CNT_W'(1) : '0;
        end else if (push_ovf) begin
            sticky_reg <= 1'b1;
            if (ovf_reg != '1) begin
                ovf_reg <= ovf_reg + 1'b1;
            end
        end
    end

    assign sticky_v  = sticky_reg;
    assign ovf_count = ovf_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_addsub_result_buffer.sv
module tb_addsub_result_buffer;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int OVF_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_result;
    logic       in_v;
    logic       in_c_out;
    logic       in_m;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [4:0] out_flags;
    logic       clr;
    logic       sticky_v;
    logic [CNT_W-1:0] ovf_count;
    logic [$clog2(DEPTH):0] count;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: a queue of {result, flags} words plus the overflow status
    logic [8:0] mq[$];
    bit         m_sticky;
    int         m_ovf;
    bit         last_push;

    always #5 clk = ~clk;

    addsub_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_v       (in_v),
        .in_c_out   (in_c_out),
        .in_m       (in_m),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .clr        (clr),
        .sticky_v   (sticky_v),
        .ovf_count  (ovf_count),
        .count      (count)
    );

    // Flags from their arithmetic meaning: {M, zero, negative, V, C}
    function automatic logic [4:0] model_flags(input int r, input bit v, input bit c, input bit m);
        return {m, r == 0, r >= 8, v, c};
    endfunction

    function automatic logic [3:0] exp_result();
        logic [8:0] w;
        if (mq.size() == 0) return 4'h0;
        w = mq[0];
        return w[8:5];
    endfunction

    function automatic logic [4:0] exp_flags();
        logic [8:0] w;
        if (mq.size() == 0) return 5'h00;
        w = mq[0];
        return w[4:0];
    endfunction

    // Drives one cycle (entered and left just after a falling edge) and
    // advances the model. It makes no comparisons.
    task automatic step(input bit vi, input int r, input bit vv, input bit cc, input bit mm,
                        input bit ordy, input bit cl);
        bit push, pop;
        logic [8:0] w;
        in_valid  = vi;
        in_result = r[3:0];
        in_v      = vv;
        in_c_out  = cc;
        in_m      = mm;
        out_ready = ordy;
        clr       = cl;
        push = vi && (mq.size() < DEPTH);
        pop  = (mq.size() > 0) && ordy;
        w = {r[3:0], model_flags(r, vv, cc, mm)};
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(w);
        if (cl) begin
            m_sticky = push && vv;
            m_ovf    = (push && vv) ? 1 : 0;
        end else if (push && vv) begin
            m_sticky = 1'b1;
            if (m_ovf < OVF_MAX) m_ovf++;
        end
        last_push = push;
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) step(0, 0, 0, 0, 0, 1, 0);
        vectors++;
        if (count !== 0) begin
            miscompares++;
            $display("FAIL drain_empty: count got %0d expected 0", count);
        end
    endtask

    task automatic test_reset();
        vectors += 7;
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (count !== 0)        begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (out_result !== 4'h0) begin miscompares++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
        if (out_flags !== 5'h0) begin miscompares++; $display("FAIL reset_out_flags: got %b expected 00000", out_flags); end
        if (sticky_v !== 1'b0)  begin miscompares++; $display("FAIL reset_sticky: got %b expected 0", sticky_v); end
        if (ovf_count !== 0)    begin miscompares++; $display("FAIL reset_ovf: got %0d expected 0", ovf_count); end
    endtask

    task automatic test_first_word();
        step(1, 5, 0, 0, 0, 1, 0);   // out_ready=1 while empty must not pop
        vectors += 3;
        if (out_valid !== 1'b1)   begin miscompares++; $display("FAIL first_valid: got %b expected 1", out_valid); end
        if (out_result !== 4'h5)  begin miscompares++; $display("FAIL first_result: got %h expected 5", out_result); end
        if (out_flags !== 5'b00000) begin miscompares++; $display("FAIL first_flags: got %b expected 00000", out_flags); end
        drain();
    endtask

    task automatic test_flags();
        logic [4:0] exp_f [3];
        logic [3:0] exp_r [3];
        exp_f[0] = 5'b10100; exp_f[1] = 5'b11001; exp_f[2] = 5'b00110;
        exp_r[0] = 4'hE;     exp_r[1] = 4'h0;     exp_r[2] = 4'h8;
        step(1, 14, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        step(1, 8, 1, 0, 0, 0, 0);
        vectors += 2;
        if (sticky_v !== 1'b1) begin miscompares++; $display("FAIL flags_sticky: got %b expected 1", sticky_v); end
        if (ovf_count !== 1)   begin miscompares++; $display("FAIL flags_ovf: got %0d expected 1", ovf_count); end
        for (int i = 0; i < 3; i++) begin
            vectors += 2;
            if (out_flags !== exp_f[i])  begin miscompares++; $display("FAIL flags_word%0d: got %b expected %b", i, out_flags, exp_f[i]); end
            if (out_result !== exp_r[i]) begin miscompares++; $display("FAIL flags_result%0d: got %h expected %h", i, out_result, exp_r[i]); end
            step(0, 0, 0, 0, 0, 1, 0);
        end
        drain();
    endtask

    task automatic test_full();
        int wr [DEPTH+2];
        int idx = 0;
        int k = 0;
        for (int i = 0; i < DEPTH + 2; i++) wr[i] = $urandom_range(15);
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1, wr[idx], 0, 0, 0, 0, 0);
            if (last_push) idx++;
        end
        vectors += 3;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        if (count !== DEPTH)   begin miscompares++; $display("FAIL full_count: got %0d expected %0d", count, DEPTH); end
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL full_out_valid: got %b expected 1", out_valid); end
        // Drain while the producer holds its pending word until it is taken
        for (int c = 0; c < 20 && k < DEPTH + 2; c++) begin
            if (out_valid === 1'b1) begin
                vectors++;
                if (out_result !== wr[k][3:0]) begin
                    miscompares++;
                    $display("FAIL full_order%0d: got %h expected %h", k, out_result, wr[k][3:0]);
                end
                k++;
            end
            step(idx < DEPTH + 2, (idx < DEPTH + 2) ? wr[idx] : 0, 0, 0, 0, 1, 0);
            if (last_push) idx++;
        end
        vectors++;
        if (k != DEPTH + 2) begin miscompares++; $display("FAIL full_drained: got %0d words expected %0d", k, DEPTH + 2); end
        drain();
    endtask

    task automatic test_back_to_back();
        step(1, $urandom_range(15), 0, 1, 0, 0, 0);
        step(1, $urandom_range(15), 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            vectors += 3;
            if (count !== 2) begin miscompares++; $display("FAIL b2b_count%0d: got %0d expected 2", i, count); end
            if (out_result !== exp_result()) begin miscompares++; $display("FAIL b2b_result%0d: got %h expected %h", i, out_result, exp_result()); end
            if (out_flags !== exp_flags())   begin miscompares++; $display("FAIL b2b_flags%0d: got %b expected %b", i, out_flags, exp_flags()); end
            step(1, $urandom_range(15), $urandom_range(1), $urandom_range(1), $urandom_range(1), 1, 0);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            vectors += 7;
            if (in_ready !== (mq.size() < DEPTH)) begin miscompares++; $display("FAIL rnd_in_ready%0d: got %b expected %b", i, in_ready, mq.size() < DEPTH); end
            if (out_valid !== (mq.size() > 0))    begin miscompares++; $display("FAIL rnd_out_valid%0d: got %b expected %b", i, out_valid, mq.size() > 0); end
            if (count !== mq.size())              begin miscompares++; $display("FAIL rnd_count%0d: got %0d expected %0d", i, count, mq.size()); end
            if (out_result !== exp_result())      begin miscompares++; $display("FAIL rnd_result%0d: got %h expected %h", i, out_result, exp_result()); end
            if (out_flags !== exp_flags())        begin miscompares++; $display("FAIL rnd_flags%0d: got %b expected %b", i, out_flags, exp_flags()); end
            if (sticky_v !== m_sticky)            begin miscompares++; $display("FAIL rnd_sticky%0d: got %b expected %b", i, sticky_v, m_sticky); end
            if (ovf_count !== m_ovf)              begin miscompares++; $display("FAIL rnd_ovf%0d: got %0d expected %0d", i, ovf_count, m_ovf); end
            step($urandom_range(3) != 0, $urandom_range(15), $urandom_range(1), $urandom_range(1),
                 $urandom_range(1), $urandom_range(1), $urandom_range(15) == 0);
        end
        drain();
    endtask

    task automatic test_saturate();
        step(0, 0, 0, 0, 0, 1, 1);
        vectors += 2;
        if (ovf_count !== 0)   begin miscompares++; $display("FAIL sat_clr_ovf: got %0d expected 0", ovf_count); end
        if (sticky_v !== 1'b0) begin miscompares++; $display("FAIL sat_clr_sticky: got %b expected 0", sticky_v); end
        for (int i = 0; i < 300; i++) step(1, $urandom_range(15), 1, $urandom_range(1), $urandom_range(1), 1, 0);
        vectors += 2;
        if (ovf_count !== OVF_MAX) begin miscompares++; $display("FAIL sat_ovf: got %0d expected %0d", ovf_count, OVF_MAX); end
        if (ovf_count !== m_ovf)   begin miscompares++; $display("FAIL sat_model: got %0d expected %0d", ovf_count, m_ovf); end
        step(1, 8, 1, 0, 0, 1, 1);
        vectors += 2;
        if (ovf_count !== 1)   begin miscompares++; $display("FAIL sat_clr_push_ovf: got %0d expected 1", ovf_count); end
        if (sticky_v !== 1'b1) begin miscompares++; $display("FAIL sat_clr_push_sticky: got %b expected 1", sticky_v); end
        drain();
    endtask

    task automatic test_async_reset();
        step(1, 8, 1, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0);
        step(1, 9, 0, 1, 1, 0, 0);
        vectors++;
        if (count !== 3) begin miscompares++; $display("FAIL arst_pre_count: got %0d expected 3", count); end
        #2 rst_n = 1'b0;
        #1;
        vectors += 7;
        if (count !== 0)         begin miscompares++; $display("FAIL arst_count: got %0d expected 0", count); end
        if (out_valid !== 1'b0)  begin miscompares++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1)   begin miscompares++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
        if (out_result !== 4'h0) begin miscompares++; $display("FAIL arst_result: got %h expected 0", out_result); end
        if (out_flags !== 5'h0)  begin miscompares++; $display("FAIL arst_flags: got %b expected 00000", out_flags); end
        if (sticky_v !== 1'b0)   begin miscompares++; $display("FAIL arst_sticky: got %b expected 0", sticky_v); end
        if (ovf_count !== 0)     begin miscompares++; $display("FAIL arst_ovf: got %0d expected 0", ovf_count); end
        mq.delete();
        m_sticky = 1'b0;
        m_ovf    = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 6, 0, 0, 0, 0, 0);
        vectors++;
        if (out_result !== 4'h6) begin miscompares++; $display("FAIL arst_after_result: got %h expected 6", out_result); end
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_result = 4'h0;
        in_v      = 1'b0;
        in_c_out  = 1'b0;
        in_m      = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        m_sticky  = 1'b0;
        m_ovf     = 0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_first_word();
        test_flags();
        test_full();
        test_back_to_back();
        test_random();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
